result_bank: RTL and testbench
==============================

// Module: result_bank
// PURPOSE
//  Output-side counterpart of the operand memory bank: the bank deserialises the W/X
//  stream into three parallel MAC lanes; result_bank captures the three parallel MAC
//  results per beat into a 3x3 result store, then serialises the row_w x col_x product
//  matrix back onto one output stream under a valid/ready handshake.
//  Sits between the MAC array and the host/readback port.
// PARAMETERS
//  ACC_W   10  MAC result width (4b x 4b product, 3-term sum -> 10b)
//  MAX_DIM 3   maximum rows/cols of the result matrix; store depth is MAX_DIM*MAX_DIM
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  clear       in   1      synchronous clear: store->0, FSM->IDLE, flags->0
//  row_w       in   2      result rows (R); sampled on the first accepted beat
//  col_x       in   2      result cols (C); sampled on the first accepted beat
//  mac_valid   in   1      MAC lanes carry one result column this cycle
//  mac_out1    in   ACC_W  result row 0 of the current column
//  mac_out2    in   ACC_W  result row 1
//  mac_out3    in   ACC_W  result row 2
//  dout        out  ACC_W  serial result element
//  dout_valid  out  1      dout holds a valid element
//  dout_ready  in   1      consumer accepts dout this cycle
//  busy        out  1      high in COLLECT or DRAIN
//  done        out  1      one-cycle pulse after the last element is accepted
//  overflow    out  1      sticky: a mac_valid beat was dropped
// BEHAVIOUR
//  Reset/clear: all outputs 0, store 0, col_cnt=0, rd_row=rd_col=0, state IDLE.
//  FSM: IDLE -> COLLECT -> DRAIN -> DONE -> IDLE.
//  IDLE: on mac_valid with R!=0 and C!=0, latch R,C and capture beat as column 0.
//    Go to COLLECT, or straight to DRAIN if C==1.
//    mac_valid with R==0 or C==0: beat ignored, stay IDLE, no flag.
//  Capture: store[r*3+col_cnt] <= mac_out{r+1} for r<R; lanes r>=R are not written.
//    col_cnt increments per accepted beat.
//  COLLECT: each mac_valid captures the next column; on the beat where col_cnt==C-1,
//    go to DRAIN. Gaps (mac_valid low) are allowed.
//  DRAIN: row-major order (r=0..R-1, c=0..C-1), dout=store[r*3+c].
//    dout_valid rises the cycle after the final capture (1-cycle latency).
//    Advance only on dout_valid&&dout_ready; dout and dout_valid are held stable while
//    stalled. After the (R*C)th handshake: dout_valid->0 and go to DONE.
//  DONE: done=1 for exactly one cycle, then IDLE. The store keeps its contents until
//    overwritten or cleared.
//  mac_valid in DRAIN or DONE: beat dropped, overflow<=1; overflow stays set until
//    reset or clear.
//  Dims changing after the latch have no effect until the next IDLE capture.
//  clear outranks everything, including a simultaneous handshake or mac_valid.
//  rst_n low mid-DRAIN: outputs drop immediately; no done pulse.
//  Registers only; no combinational path from mac_* to dout.
//    dout_ready->state is the only same-cycle dependency.
// STRUCTURE
//  Shared package/header: ACC_W, MAX_DIM, state encodings (ST_IDLE/COLLECT/DRAIN/DONE),
//    store index helper idx(r,c)=r*MAX_DIM+c.
//  One sub-module: result_drain_ctr, the nested row/col read counter with wrap and
//    last-element flag. It is reusable for operand readback.
//  Storage: flat reg array [0:MAX_DIM*MAX_DIM-1][ACC_W-1:0].
// TESTING
//  R=2,C=2; beats {1,2,x} then {3,4,x}; dout_ready=1
//    -> dout 1,3,2,4 on 4 consecutive cycles, then done pulse.
//  R=3,C=3 with 9 distinct values; dout_ready toggled 1/0
//    -> order preserved, dout held stable while ready=0, exactly 9 handshakes.
//  R=1,C=1 single beat mac_out1=1023 -> DRAIN next cycle, dout=1023, done 1 cycle after
//    the handshake.
//  mac_valid pulsed during DRAIN -> overflow=1 and stays 1; the drained data is
//    unchanged; clear -> overflow=0.
//  R=0 with mac_valid -> stays IDLE, busy=0, no output; then R=2,C=1 -> 2 elements.
//  rst_n low after 2 of 4 elements drained -> all outputs 0 asynchronously.
//    Next matrix after reset drains correctly from index 0.

Source files
------------

// File: rtl/result_bank_pkg.sv
// Shared constants, FSM encoding and store addressing for the result bank.
package result_bank_pkg;
    localparam int ACC_W   = 10;
    localparam int MAX_DIM = 3;
    localparam int DEPTH   = MAX_DIM * MAX_DIM;
    localparam int DIM_W   = 2;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [IDX_W-1:0] idx(input logic [DIM_W-1:0] r,
                                             input logic [DIM_W-1:0] c);
        return IDX_W'(int'(r) * MAX_DIM + int'(c));
    endfunction
endpackage

// File: rtl/result_bank_if.sv
// MAC-side capture inputs plus the serial readback stream of the result bank.
interface result_bank_if;
    import result_bank_pkg::*;

    logic             clear;
    logic [DIM_W-1:0] row_w;
    logic [DIM_W-1:0] col_x;
    logic             mac_valid;
    logic [ACC_W-1:0] mac_out1;
    logic [ACC_W-1:0] mac_out2;
    logic [ACC_W-1:0] mac_out3;
    logic [ACC_W-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output clear, row_w, col_x, mac_valid, mac_out1, mac_out2, mac_out3, dout_ready,
        input  dout, dout_valid, busy, done, overflow
    );

    modport slave (
        input  clear, row_w, col_x, mac_valid, mac_out1, mac_out2, mac_out3, dout_ready,
        output dout, dout_valid, busy, done, overflow
    );
endinterface

// File: rtl/result_bank_drain_ctr.sv
// Nested row/col read counter: walks row-major over rows_i x cols_i, wraps to (0,0).
module result_drain_ctr #(
    parameter int DIM_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             adv_i,
    input  logic [DIM_W-1:0] rows_i,
    input  logic [DIM_W-1:0] cols_i,
    output logic [DIM_W-1:0] row_o,
    output logic [DIM_W-1:0] col_o,
    output logic             last_o
);
    logic [DIM_W-1:0] row_q, col_q;
    logic             row_last, col_last;

    assign row_last = (row_q == rows_i - DIM_W'(1));
    assign col_last = (col_q == cols_i - DIM_W'(1));
    assign last_o   = row_last && col_last;
    assign row_o    = row_q;
    assign col_o    = col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (clr_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (adv_i) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + DIM_W'(1);
            end else begin
                col_q <= col_q + DIM_W'(1);
            end
        end
    end
endmodule

// File: rtl/result_bank.sv
// Captures 3-lane MAC result columns into a 3x3 store, then streams the RxC matrix row-major.
module result_bank
    import result_bank_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    result_bank_if.slave bus
);
    state_t           state_q, state_d;
    logic [DIM_W-1:0] rows_q, rows_d, cols_q, cols_d, col_cnt_q, col_cnt_d;
    logic [DIM_W-1:0] cap_col, cap_rows;
    logic [DIM_W-1:0] rd_row, rd_col;
    logic [ACC_W-1:0] store_q [DEPTH];
    logic [ACC_W-1:0] lane [MAX_DIM];
    logic             accept, hs, rd_last, overflow_q, drain;

    assign lane[0] = bus.mac_out1;
    assign lane[1] = bus.mac_out2;
    assign lane[2] = bus.mac_out3;

    assign drain = (state_q == ST_DRAIN);
    assign hs    = drain && bus.dout_ready;

    always_comb begin
        state_d   = state_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        col_cnt_d = col_cnt_q;
        cap_col   = col_cnt_q;
        cap_rows  = rows_q;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cap_col   = '0;
                cap_rows  = bus.row_w;
                col_cnt_d = '0;
                if (bus.mac_valid && bus.row_w != '0 && bus.col_x != '0) begin
                    accept    = 1'b1;
                    rows_d    = bus.row_w;
                    cols_d    = bus.col_x;
                    col_cnt_d = DIM_W'(1);
                    state_d   = (bus.col_x == DIM_W'(1)) ? ST_DRAIN : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (bus.mac_valid) begin
                    accept    = 1'b1;
                    col_cnt_d = col_cnt_q + DIM_W'(1);
                    if (col_cnt_q == cols_q - DIM_W'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (hs && rd_last) state_d = ST_DONE;
            end
            ST_DONE: begin
                col_cnt_d = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // clear wins over any capture or handshake in the same cycle
        if (bus.clear) begin
            state_d   = ST_IDLE;
            col_cnt_d = '0;
            accept    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rows_q     <= '0;
            cols_q     <= '0;
            col_cnt_q  <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            col_cnt_q <= col_cnt_d;
            if (bus.clear) begin
                overflow_q <= 1'b0;
                for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
            end else begin
                if (bus.mac_valid && (state_q == ST_DRAIN || state_q == ST_DONE))
                    overflow_q <= 1'b1;
                if (accept) begin
                    for (int r = 0; r < MAX_DIM; r++)
                        if (DIM_W'(r) < cap_rows) store_q[idx(DIM_W'(r), cap_col)] <= lane[r];
                end
            end
        end
    end

    result_drain_ctr #(.DIM_W(DIM_W)) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (bus.clear),
        .adv_i  (hs && !bus.clear),
        .rows_i (rows_q),
        .cols_i (cols_q),
        .row_o  (rd_row),
        .col_o  (rd_col),
        .last_o (rd_last)
    );

    assign bus.dout_valid = drain;
    assign bus.dout       = drain ? store_q[idx(rd_row, rd_col)] : '0;
    assign bus.busy       = (state_q == ST_COLLECT) || drain;
    assign bus.done       = (state_q == ST_DONE);
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_result_bank.sv
// Directed bench for result_bank: expected elements queued at capture, popped on handshake.
module tb_result_bank;
    import result_bank_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    result_bank_if bus();

    result_bank dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    logic [ACC_W-1:0] exp_q [$];
    logic [ACC_W-1:0] exp_v;
    logic [ACC_W-1:0] stall_val;
    logic             stall_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every handshake pops one expected element; stalls must hold dout.
    always @(negedge clk) begin
        if (bus.dout_valid === 1'b1) begin
            if (stall_seen) begin
                checks++;
                assert (bus.dout === stall_val) else begin
                    errors++;
                    $error("FAIL hold observed=%0d expected=%0d", bus.dout, stall_val);
                end
            end
            if (bus.dout_ready === 1'b1) begin
                hs_cnt++;
                stall_seen = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL dout_extra observed=%0d expected=none", bus.dout);
                end else begin
                    exp_v = exp_q.pop_front();
                    assert (bus.dout === exp_v) else begin
                        errors++;
                        $error("FAIL dout observed=%0d expected=%0d", bus.dout, exp_v);
                    end
                end
            end else begin
                stall_seen = 1'b1;
                stall_val  = bus.dout;
            end
        end else begin
            stall_seen = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [DIM_W-1:0] r, input logic [DIM_W-1:0] c,
                        input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b,
                        input logic [ACC_W-1:0] d);
        bus.row_w     = r;
        bus.col_x     = c;
        bus.mac_out1  = a;
        bus.mac_out2  = b;
        bus.mac_out3  = d;
        bus.mac_valid = 1'b1;
        step();
        bus.mac_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk(tag, 32'(bus.done), 1);
    endtask

    initial begin
        bus.clear      = 1'b0;
        bus.row_w      = '0;
        bus.col_x      = '0;
        bus.mac_valid  = 1'b0;
        bus.mac_out1   = '0;
        bus.mac_out2   = '0;
        bus.mac_out3   = '0;
        bus.dout_ready = 1'b0;
        repeat (2) step();
        chk("rst_dout_valid", 32'(bus.dout_valid), 0);
        chk("rst_dout", 32'(bus.dout), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_overflow", 32'(bus.overflow), 0);
        rst_n = 1'b1;
        step();

        // 2x2, continuous ready: 1,3,2,4 back to back then done
        bus.dout_ready = 1'b1;
        hs_cnt = 0;
        exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(2); exp_q.push_back(4);
        beat(2, 2, 1, 2, 9);
        chk("t1_busy_collect", 32'(bus.busy), 1);
        chk("t1_valid_early", 32'(bus.dout_valid), 0);
        beat(2, 2, 3, 4, 9);
        chk("t1_valid", 32'(bus.dout_valid), 1);
        repeat (4) step();
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_hs", 32'(hs_cnt), 4);
        chk("t1_valid_off", 32'(bus.dout_valid), 0);
        step();
        chk("t1_done_pulse", 32'(bus.done), 0);
        chk("t1_q_empty", 32'(exp_q.size()), 0);

        // 3x3 with gaps, later beats carry other dims (ignored), ready toggling
        bus.dout_ready = 1'b0;
        hs_cnt = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) exp_q.push_back(ACC_W'(100 * r + 10 * c + 5));
        for (int c = 0; c < 3; c++) begin
            beat((c == 0) ? 2'd3 : 2'd1, (c == 0) ? 2'd3 : 2'd1,
                 ACC_W'(10 * c + 5), ACC_W'(100 + 10 * c + 5), ACC_W'(200 + 10 * c + 5));
            step();
        end
        for (int n = 0; n < 60 && bus.done !== 1'b1; n++) begin
            bus.dout_ready = ~bus.dout_ready;
            step();
        end
        chk("t2_done", 32'(bus.done), 1);
        chk("t2_hs", 32'(hs_cnt), 9);
        chk("t2_q_empty", 32'(exp_q.size()), 0);
        step();

        // 1x1 full-scale value: drain immediately
        bus.dout_ready = 1'b1;
        exp_q.push_back(1023);
        beat(1, 1, 1023, 5, 6);
        chk("t3_valid", 32'(bus.dout_valid), 1);
        chk("t3_dout", 32'(bus.dout), 1023);
        step();
        chk("t3_done", 32'(bus.done), 1);
        step();
        chk("t3_done_pulse", 32'(bus.done), 0);

        // beat during DRAIN is dropped and flags overflow; clear resets the flag
        bus.dout_ready = 1'b0;
        exp_q.push_back(11); exp_q.push_back(13); exp_q.push_back(12); exp_q.push_back(14);
        beat(2, 2, 11, 12, 0);
        beat(2, 2, 13, 14, 0);
        chk("t4_ovf_before", 32'(bus.overflow), 0);
        beat(2, 2, 100, 200, 300);
        chk("t4_ovf_set", 32'(bus.overflow), 1);
        step();
        bus.dout_ready = 1'b1;
        wait_done("t4_done");
        chk("t4_ovf_sticky", 32'(bus.overflow), 1);
        chk("t4_q_empty", 32'(exp_q.size()), 0);
        step();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("t4_ovf_clear", 32'(bus.overflow), 0);

        // zero dims ignored silently, then a 2x1 matrix
        beat(0, 2, 5, 5, 5);
        chk("t5_busy_r0", 32'(bus.busy), 0);
        beat(2, 0, 5, 5, 5);
        chk("t5_busy_c0", 32'(bus.busy), 0);
        chk("t5_valid", 32'(bus.dout_valid), 0);
        chk("t5_ovf", 32'(bus.overflow), 0);
        exp_q.push_back(7); exp_q.push_back(8);
        beat(2, 1, 7, 8, 9);
        chk("t5_drain", 32'(bus.dout_valid), 1);
        wait_done("t5_done");
        chk("t5_q_empty", 32'(exp_q.size()), 0);
        step();

        // async reset after two of four elements, then a fresh matrix from index 0
        hs_cnt = 0;
        exp_q.push_back(21); exp_q.push_back(23); exp_q.push_back(22); exp_q.push_back(24);
        beat(2, 2, 21, 22, 0);
        beat(2, 2, 23, 24, 0);
        repeat (2) step();
        chk("t6_hs", 32'(hs_cnt), 2);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(bus.dout_valid), 0);
        chk("t6_dout", 32'(bus.dout), 0);
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_done", 32'(bus.done), 0);
        exp_q.delete();
        repeat (2) step();
        chk("t6_no_done", 32'(bus.done), 0);
        rst_n = 1'b1;
        step();
        exp_q.push_back(31); exp_q.push_back(33); exp_q.push_back(32); exp_q.push_back(34);
        beat(2, 2, 31, 32, 0);
        beat(2, 2, 33, 34, 0);
        wait_done("t6_done_after");
        chk("t6_q_empty", 32'(exp_q.size()), 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
